sub_bytes_lanes: RTL

Parametrised AES SubBytes engine, the successor to the fixed 128-bit SubBytes stage in the PF_AES datapath. It substitutes the 16 state bytes through LANES S-box instances time-multiplexed over 16/LANES cycles, trading area against latency. It also supports inverse SubBytes (InvS-box) for the decrypt round path. It keeps the En/Ry handshake of the existing round blocks, so the AES round controller drives it the same way.

---
 rtl/sub_bytes_lanes_if.sv | 28 ++
 rtl/sub_bytes_lanes.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_lanes_if.sv
// sub_bytes_lanes_if: En/Ry handshake and state bus between the AES round
// controller (master) and the SubBytes engine (slave).
interface sub_bytes_lanes_if;
  logic         En_SBT;
  logic         Dec_SBT;
  logic [127:0] In_SBT;
  logic [127:0] Out_SBT;
  logic         Ry_SBT;
  logic         Bsy_SBT;

  modport master (
    output En_SBT,
    output Dec_SBT,
    output In_SBT,
    input  Out_SBT,
    input  Ry_SBT,
    input  Bsy_SBT
  );

  modport slave (
    input  En_SBT,
    input  Dec_SBT,
    input  In_SBT,
    output Out_SBT,
    output Ry_SBT,
    output Bsy_SBT
  );
endinterface

// File: rtl/sub_bytes_lanes.sv
// sub_bytes_lanes: AES SubBytes / InvSubBytes over a 128-bit state using
// LANES byte substitution units, time-multiplexed over N = 16/LANES cycles.
// Chunks are processed MSB-first; the result register only updates on the
// completion edge, so partial states are never visible on Out_SBT.
// LANES must be one of 1, 2, 4, 8, 16.
module sub_bytes_lanes #(
  parameter int LANES = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  sub_bytes_lanes_if.slave  sbt
);

  localparam int          N          = 16 / LANES;
  localparam logic [4:0]  LAST_CHUNK = 5'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [4:0]     cnt_q;
  logic [127:0]   work_q;
  logic           mode_q;
  logic [127:0]   out_q;
  logic           ry_q;
  logic           bsy_q;

  logic [127:0]   src_s;
  logic           dec_s;
  int             chunk_s;
  int             idx_s;
  logic [127:0]   sub_s;

  // Rotate a byte left by k bit positions (k in 1..7).
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = a;
    // 254 = 8'b1111_1110: multiply in a^(2^i) for i = 1..7
    for (int i = 0; i < 8; i++) begin
      if (i != 0) begin
        r = gf_mul(r, t);
      end else begin
        r = r;
      end
      t = gf_mul(t, t);
    end
    return r;
  endfunction

  // Forward affine transform of the S-box.
  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  // Inverse affine transform used by the InvS-box.
  function automatic logic [7:0] affine_inv(input logic [7:0] s);
    return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
  endfunction

  // One substitution lane; the field inverter is shared by both directions.
  function automatic logic [7:0] sbox_byte(input logic [7:0] b, input logic dec);
    logic [7:0] x;
    logic [7:0] y;
    if (dec) begin
      x = affine_inv(b);
    end else begin
      x = b;
    end
    y = gf_inv(x);
    if (dec) begin
      return y;
    end else begin
      return affine_fwd(y);
    end
  endfunction

  // Select the state, direction and chunk feeding the lanes this cycle.
  always_comb begin
    src_s   = work_q;
    dec_s   = mode_q;
    chunk_s = 0;
    if (state_q == IDLE) begin
      src_s   = sbt.In_SBT;
      dec_s   = sbt.Dec_SBT;
      chunk_s = 0;
    end else if (state_q == RUN) begin
      chunk_s = int'(cnt_q);
    end else begin
      chunk_s = 0;
    end
  end

  // Substitute the selected chunk; all other bytes pass through unchanged.
  always_comb begin
    sub_s = src_s;
    idx_s = 0;
    for (int j = 0; j < LANES; j++) begin
      idx_s = 15 - chunk_s * LANES - j;
      sub_s[8*idx_s +: 8] = sbox_byte(src_s[8*idx_s +: 8], dec_s);
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      work_q  <= 128'd0;
      mode_q  <= 1'b0;
      out_q   <= 128'd0;
      ry_q    <= 1'b0;
      bsy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sbt.En_SBT) begin
            mode_q <= sbt.Dec_SBT;
            work_q <= sub_s;
            cnt_q  <= 5'd1;
            if (N == 1) begin
              out_q   <= sub_s;
              ry_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              bsy_q   <= 1'b1;
              state_q <= RUN;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          work_q <= sub_s;
          if (cnt_q == LAST_CHUNK) begin
            out_q   <= sub_s;
            ry_q    <= 1'b1;
            bsy_q   <= 1'b0;
            cnt_q   <= 5'd0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        DONE: begin
          // Restart requires En low for a cycle; holding En keeps the result.
          if (!sbt.En_SBT) begin
            ry_q    <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 5'd0;
          ry_q    <= 1'b0;
          bsy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sbt.Out_SBT = out_q;
  assign sbt.Ry_SBT  = ry_q;
  assign sbt.Bsy_SBT = bsy_q;

endmodule
